frame_scanner: RTL
==================

FRAME_SCANNER -- requirements
Module: frame_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 320, pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 240, lines per frame.
REQ-003 SHALL have parameter LATENCY, default 1, renderer clocks from coordinate to valid colour; legal range 1..4.
REQ-004 SHALL have port clock, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, request one full-frame scan.
REQ-007 SHALL have port colour_in, input, 3, colour returned by the renderer (background flag).
REQ-008 SHALL have port x_cord, output, 9, column driven to the renderer.
REQ-009 SHALL have port y_cord, output, 9, row driven to the renderer.
REQ-010 SHALL have port plot, output, 1, write strobe to the VGA adapter.
REQ-011 SHALL have port x_out, output, 9, column for the plot.
REQ-012 SHALL have port y_out, output, 9, row for the plot.
REQ-013 SHALL have port colour_out, output, 3, colour for the plot.
REQ-014 SHALL have port busy, output, 1, high in SCAN or FLUSH.
REQ-015 SHALL have port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement states IDLE, SCAN, FLUSH, DONE.
REQ-017 IDLE: start=1 -> SCAN next edge with x_cord=0, y_cord=0; start ignored in every other state.
REQ-018 SCAN: x_cord increments once per clock; at x_cord=WIDTH-1 it wraps to 0 and y_cord increments.
REQ-019 SCAN: at x_cord=WIDTH-1 and y_cord=HEIGHT-1 -> FLUSH; x_cord/y_cord hold the last pixel during FLUSH.
REQ-020 Each coordinate issued in SCAN SHALL be tagged valid and delayed LATENCY stages; tag, x, y travel together.
REQ-021 On each edge, the output register SHALL load plot = delayed tag, x_out/y_out = delayed coordinate, colour_out = colour_in; total coordinate-to-plot latency LATENCY+1 clocks.
REQ-022 Exactly WIDTH*HEIGHT plot pulses per frame (76800 default), in raster order, no gaps, no duplicates.
REQ-023 FLUSH SHALL last LATENCY+1 clocks, ending on the clock the final plot (WIDTH-1, HEIGHT-1) is visible, then -> DONE.
REQ-024 DONE SHALL assert done for exactly one clock, then -> IDLE (see REQ-031).
REQ-025 Counters SHALL be 9-bit unsigned; no value >= WIDTH or >= HEIGHT ever reaches x_cord/y_cord.
REQ-026 When plot=0, x_out/y_out/colour_out hold their previous values.

Reset
REQ-027 reset=1 SHALL asynchronously force IDLE, x_cord=0, y_cord=0, all delay tags=0, plot=0, x_out=0, y_out=0, colour_out=0, busy=0, done=0.
REQ-028 reset asserted mid-frame SHALL abort the frame; no plot pulse after reset asserts, including in-flight pipeline entries.
REQ-029 After reset release, start is required to begin a frame (unless REQ-031 applies).

Configuration
REQ-030 Macro FRAME_SCANNER_AUTO_RESTART_EN SHALL select continuous scanning.
REQ-031 Defined: DONE -> SCAN directly (x_cord=0, y_cord=0), done still pulses; IDLE -> SCAN on first clock after reset release, start ignored.
REQ-032 Undefined: behaviour per REQ-017/REQ-024; frame begins only on start.

Structure
REQ-033 Shared package frame_pkg SHALL hold the state enumeration, default WIDTH/HEIGHT, and the 3-bit colour constants (black 3'b000, white 3'b111).
REQ-034 The delay line SHALL be sub-module pixel_delay (parameter LATENCY; carries tag, x, y; async reset clears tags).

Verification
REQ-035 Reset, start pulse 1 clock, renderer model (registered, LATENCY=1, colour = x[2:0]) -> 76800 plots, first (0,0,000) on clock 2 after SCAN entry, last (319,239,111), done one clock after.
REQ-036 start held high through whole frame -> one frame only, done once, IDLE afterwards (macro undefined).
REQ-037 reset asserted at pixel (100,50) -> plot low same cycle; next start restarts at (0,0).
REQ-038 WIDTH=4, HEIGHT=3, LATENCY=3 -> 12 plots in raster order, FLUSH 4 clocks, busy high from SCAN entry through final plot.
REQ-039 Line wrap: plot sequence ...(319,0),(0,1)... with no gap or repeat at the boundary.
REQ-040 FRAME_SCANNER_AUTO_RESTART_EN defined, no start -> back-to-back frames, done pulses every 76800+LATENCY+2 clocks.

Source files
------------

// File: rtl/frame_pkg.sv
// frame_pkg: scanner state encoding, default raster size and colour constants
package frame_pkg;
   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;
   localparam int DEF_WIDTH = 320;
   localparam int DEF_HEIGHT = 240;
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
endpackage

// File: rtl/pixel_delay.sv
// pixel_delay: LATENCY-stage shift line carrying a valid tag with its x/y coordinate
module pixel_delay #(
   parameter int LATENCY = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tag_in,
   input  logic [8:0] x_in,
   input  logic [8:0] y_in,
   output logic       tag_out,
   output logic [8:0] x_out,
   output logic [8:0] y_out
);
   logic [LATENCY-1:0][18:0] pipe;
   // shift tag and coordinate together; reset empties the line so in-flight pixels are dropped
   always_ff @(posedge clock or posedge reset)
      if (reset) pipe <= '0;
      else begin
         pipe[0] <= {tag_in, y_in, x_in};
         for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   assign {tag_out, y_out, x_out} = pipe[LATENCY-1];
endmodule

// File: rtl/frame_scanner.sv
// frame_scanner: raster scan of a frame through a renderer into VGA plot strobes (FRAME_SCANNER_AUTO_RESTART_EN = continuous frames)
module frame_scanner
   import frame_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int HEIGHT  = DEF_HEIGHT,
   parameter int LATENCY = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] colour_in,
   output logic [8:0] x_cord,
   output logic [8:0] y_cord,
   output logic       plot,
   output logic [8:0] x_out,
   output logic [8:0] y_out,
   output logic [2:0] colour_out,
   output logic       busy,
   output logic       done
);
   state_t     state;
   logic [2:0] flush_cnt;
   logic       go, x_last, y_last, d_tag;
   logic [8:0] d_x, d_y;
`ifdef FRAME_SCANNER_AUTO_RESTART_EN
   assign go = 1'b1;
`else
   assign go = start;
`endif
   assign x_last = x_cord == 9'(WIDTH - 1);
   assign y_last = y_cord == 9'(HEIGHT - 1);
   // scan sequencer: raster counters, flush wait for the pipeline to drain, end-of-frame pulse
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state     <= IDLE;
         x_cord    <= '0;
         y_cord    <= '0;
         flush_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (go) begin
                  state  <= SCAN;
                  x_cord <= '0;
                  y_cord <= '0;
                  busy   <= 1'b1;
               end
            SCAN:
               if (x_last && y_last) begin
                  state     <= FLUSH;
                  flush_cnt <= '0;
               end else if (x_last) begin
                  x_cord <= '0;
                  y_cord <= y_cord + 9'd1;
               end else x_cord <= x_cord + 9'd1;
            FLUSH:
               if (flush_cnt == 3'(LATENCY)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else flush_cnt <= flush_cnt + 3'd1;
            DONE: begin
`ifdef FRAME_SCANNER_AUTO_RESTART_EN
               state  <= SCAN;
               x_cord <= '0;
               y_cord <= '0;
               busy   <= 1'b1;
`else
               state <= IDLE;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   pixel_delay #(.LATENCY(LATENCY)) u_delay (
      .clock  (clock),
      .reset  (reset),
      .tag_in (state == SCAN),
      .x_in   (x_cord),
      .y_in   (y_cord),
      .tag_out(d_tag),
      .x_out  (d_x),
      .y_out  (d_y)
   );
   // plot register: strobe follows the delayed tag, pixel data only updates on a valid pixel
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         plot       <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         colour_out <= BLACK;
      end else begin
         plot <= d_tag;
         if (d_tag) begin
            x_out      <= d_x;
            y_out      <= d_y;
            colour_out <= colour_in;
         end
      end
endmodule
